// File: rtl/tkg_mutexn.sv
// N-way clocked mutual-exclusion element with four-phase req/gnt handshakes.
// Round-robin or fixed-priority arbitration, registered outputs, mandatory gap.
module tkg_mutexn #(
    parameter int N  = 4,
    parameter bit RR = 1'b1,
    parameter int OW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic [OW-1:0] owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;

    logic [N-1:0]  mask_hi;
    logic [N-1:0]  req_hi;
    logic [OW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic          own_req;

    function automatic logic [OW-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest = OW'(i);
            end
        end
    endfunction

    // Channels above the last grantee get first look; otherwise wrap to 0.
    always_comb begin
        mask_hi = '0;
        for (int i = 0; i < N; i++) begin
            mask_hi[i] = (i > int'(last_q));
        end
    end

    assign req_hi  = req & mask_hi;
    assign win_idx = (RR && (|req_hi)) ? lowest(req_hi) : lowest(req);
    assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win_idx;
    assign own_req = |(req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = win_oh;
                    busy_d  = 1'b1;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= OW'(N - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign owner = owner_q;

    a_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(gnt_q));
    a_busy: assert property (@(posedge clk) disable iff (reset)
        busy_q == (|gnt_q));
    a_gap: assert property (@(posedge clk) disable iff (reset)
        (state_q == GAP) |-> (gnt_q == '0));

endmodule

// File: tb/tb_tkg_mutexn.sv
// Scoreboarded bench for tkg_mutexn: RR N=4, fixed-priority N=4, RR N=16.
module tb_tkg_mutexn;

    logic        clk;
    logic        reset;
    logic [3:0]  req4, gnt4, reqf, gntf;
    logic [15:0] req16, gnt16;
    logic [1:0]  own4, ownf;
    logic [3:0]  own16;
    logic        busy4, busyf, busy16;

    int total;
    int bad;
    int q4[$];
    int qf[$];
    int q16[$];
    logic [3:0]  prev4, prevf;
    logic [15:0] prev16;

    tkg_mutexn #(.N(4), .RR(1'b1)) dut_rr (
        .clk(clk), .reset(reset), .req(req4),
        .gnt(gnt4), .busy(busy4), .owner(own4)
    );

    tkg_mutexn #(.N(4), .RR(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .req(reqf),
        .gnt(gntf), .busy(busyf), .owner(ownf)
    );

    tkg_mutexn #(.N(16), .RR(1'b1)) dut_16 (
        .clk(clk), .reset(reset), .req(req16),
        .gnt(gnt16), .busy(busy16), .owner(own16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-DUT monitors: invariants every cycle, gap between owners,
    // and each new grant popped against the scoreboard.
    always @(negedge clk) begin
        total++;
        if ($countones(gnt4) > 1 || busy4 !== (|gnt4) ||
            (busy4 && gnt4[own4] !== 1'b1)) begin
            bad++;
            $display("FAIL inv4 gnt=%b busy=%b owner=%0d", gnt4, busy4, own4);
        end
        if (gnt4 != 0 && prev4 != 0 && gnt4 != prev4) begin
            bad++;
            $display("FAIL gap4 got %b after %b without idle", gnt4, prev4);
        end
        if (gnt4 != 0 && prev4 == 0) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL grant4 unexpected owner=%0d", own4);
            end else begin
                int e;
                e = q4.pop_front();
                if (int'(own4) != e || gnt4 != 4'(1 << e)) begin
                    bad++;
                    $display("FAIL grant4 got owner=%0d gnt=%b want owner=%0d",
                             own4, gnt4, e);
                end
            end
        end
        prev4 = gnt4;
    end

    always @(negedge clk) begin
        total++;
        if ($countones(gntf) > 1 || busyf !== (|gntf) ||
            (busyf && gntf[ownf] !== 1'b1)) begin
            bad++;
            $display("FAIL invf gnt=%b busy=%b owner=%0d", gntf, busyf, ownf);
        end
        if (gntf != 0 && prevf == 0) begin
            total++;
            if (qf.size() == 0) begin
                bad++;
                $display("FAIL grantf unexpected owner=%0d", ownf);
            end else begin
                int e;
                e = qf.pop_front();
                if (int'(ownf) != e || gntf != 4'(1 << e)) begin
                    bad++;
                    $display("FAIL grantf got owner=%0d gnt=%b want owner=%0d",
                             ownf, gntf, e);
                end
            end
        end
        prevf = gntf;
    end

    always @(negedge clk) begin
        total++;
        if ($countones(gnt16) > 1 || busy16 !== (|gnt16) ||
            (busy16 && gnt16[own16] !== 1'b1)) begin
            bad++;
            $display("FAIL inv16 gnt=%h busy=%b owner=%0d", gnt16, busy16, own16);
        end
        if (gnt16 != 0 && prev16 == 0) begin
            total++;
            if (q16.size() == 0) begin
                bad++;
                $display("FAIL grant16 unexpected owner=%0d", own16);
            end else begin
                int e;
                e = q16.pop_front();
                if (int'(own16) != e || gnt16 != 16'(1 << e)) begin
                    bad++;
                    $display("FAIL grant16 got owner=%0d gnt=%h want owner=%0d",
                             own16, gnt16, e);
                end
            end
        end
        prev16 = gnt16;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (gnt4 !== 4'b0 || busy4 !== 1'b0 || own4 !== 2'd0) begin
            bad++;
            $display("FAIL reset4 got gnt=%b busy=%b owner=%0d want 0000/0/0",
                     gnt4, busy4, own4);
        end
        total++;
        if (gnt16 !== 16'h0 || own16 !== 4'd0) begin
            bad++;
            $display("FAIL reset16 got gnt=%h owner=%0d want 0/0", gnt16, own16);
        end
        reset = 1'b0;
        req4 = 4'b0001;
        q4.push_back(0);
        @(negedge clk);
        total++;
        if (gnt4 !== 4'b0001 || own4 !== 2'd0 || busy4 !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got gnt=%b owner=%0d busy=%b want 0001/0/1",
                     gnt4, own4, busy4);
        end
        req4 = 4'b0000;
        @(negedge clk);
        total++;
        if (gnt4 !== 4'b0000 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL single_release got gnt=%b busy=%b want 0000/0",
                     gnt4, busy4);
        end
        idle(2);
    endtask

    task automatic test_rr_rotation;
        int seen;
        int n;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q4.push_back(0);
        q4.push_back(1);
        q4.push_back(2);
        q4.push_back(3);
        q4.push_back(0);
        req4 = 4'hF;
        seen = 0;
        n = 0;
        while (seen < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (gnt4 != 0) begin
                seen++;
                req4 = 4'hF & ~gnt4;
            end else begin
                req4 = 4'hF;
            end
        end
        req4 = 4'b0000;
        total++;
        if (seen != 5) begin
            bad++;
            $display("FAIL rr_count got %0d grants want 5 in %0d cycles", seen, n);
        end
        idle(3);
        total++;
        if (q4.size() != 0) begin
            bad++;
            $display("FAIL rr_pending got %0d left want 0", q4.size());
            q4.delete();
        end
    endtask

    task automatic test_fixed;
        reqf = 4'b0010;
        qf.push_back(1);
        @(negedge clk);
        total++;
        if (gntf !== 4'b0010) begin
            bad++;
            $display("FAIL fp_first got %b want 0010", gntf);
        end
        reqf = 4'b0000;
        @(negedge clk);
        reqf = 4'b1010;
        qf.push_back(1);
        @(negedge clk);
        total++;
        if (gntf !== 4'b0000) begin
            bad++;
            $display("FAIL fp_gap got %b want 0000", gntf);
        end
        @(negedge clk);
        total++;
        if (gntf !== 4'b0010 || ownf !== 2'd1) begin
            bad++;
            $display("FAIL fp_regrant got %b owner=%0d want 0010/1", gntf, ownf);
        end
        reqf = 4'b1000;
        qf.push_back(3);
        idle(2);
        total++;
        if (gntf !== 4'b0000) begin
            bad++;
            $display("FAIL fp_gap2 got %b want 0000", gntf);
        end
        @(negedge clk);
        total++;
        if (gntf !== 4'b1000 || ownf !== 2'd3) begin
            bad++;
            $display("FAIL fp_ch3 got %b owner=%0d want 1000/3", gntf, ownf);
        end
        reqf = 4'b0000;
        idle(3);
        total++;
        if (qf.size() != 0) begin
            bad++;
            $display("FAIL fp_pending got %0d left want 0", qf.size());
            qf.delete();
        end
    endtask

    task automatic test_held;
        req4 = 4'b0100;
        q4.push_back(2);
        @(negedge clk);
        total++;
        if (gnt4 !== 4'b0100) begin
            bad++;
            $display("FAIL held_grant got %b want 0100", gnt4);
        end
        req4 = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (gnt4 !== 4'b0100 || own4 !== 2'd2) begin
                bad++;
                $display("FAIL held_cycle%0d got %b owner=%0d want 0100/2",
                         i, gnt4, own4);
            end
        end
    endtask

    task automatic test_reset_hold;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (gnt4 !== 4'b0 || own4 !== 2'd0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold got gnt=%b owner=%0d busy=%b want 0000/0/0",
                     gnt4, own4, busy4);
        end
        reset = 1'b0;
        q4.push_back(0);
        @(negedge clk);
        total++;
        if (gnt4 !== 4'b0001) begin
            bad++;
            $display("FAIL rst_first got %b want 0001", gnt4);
        end
        req4 = 4'b0000;
        idle(3);
        total++;
        if (q4.size() != 0) begin
            bad++;
            $display("FAIL rst_pending got %0d left want 0", q4.size());
            q4.delete();
        end
    endtask

    task automatic test_back_to_back;
        int n;
        req4 = 4'b0001;
        q4.push_back(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt4 == 0 && n < 5);
        total++;
        if (gnt4 !== 4'b0001 || n != 1) begin
            bad++;
            $display("FAIL b2b_first got %b after %0d want 0001 after 1", gnt4, n);
        end
        req4 = 4'b0000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (req4 == 0 && gnt4 == 0) begin
                req4 = 4'b0001;
                q4.push_back(0);
            end
        end while (gnt4 == 0 && n < 10);
        total++;
        if (gnt4 !== 4'b0001 || n != 3) begin
            bad++;
            $display("FAIL b2b_spacing got %b after %0d want 0001 after 3", gnt4, n);
        end
        req4 = 4'b0000;
        idle(3);
        total++;
        if (q4.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending got %0d left want 0", q4.size());
            q4.delete();
        end
    endtask

    task automatic test_wrap16;
        req16 = 16'h8000;
        q16.push_back(15);
        @(negedge clk);
        total++;
        if (gnt16 !== 16'h8000 || own16 !== 4'd15) begin
            bad++;
            $display("FAIL w16_last got %h owner=%0d want 8000/15", gnt16, own16);
        end
        req16 = 16'h0000;
        @(negedge clk);
        total++;
        if (gnt16 !== 16'h0000) begin
            bad++;
            $display("FAIL w16_release got %h want 0000", gnt16);
        end
        req16 = 16'h4001;
        q16.push_back(0);
        @(negedge clk);
        total++;
        if (gnt16 !== 16'h0000) begin
            bad++;
            $display("FAIL w16_gap got %h want 0000", gnt16);
        end
        @(negedge clk);
        total++;
        if (gnt16 !== 16'h0001 || own16 !== 4'd0) begin
            bad++;
            $display("FAIL w16_wrap got %h owner=%0d want 0001/0", gnt16, own16);
        end
        req16 = 16'h0000;
        idle(3);
        total++;
        if (q16.size() != 0) begin
            bad++;
            $display("FAIL w16_pending got %0d left want 0", q16.size());
            q16.delete();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        prev4 = '0;
        prevf = '0;
        prev16 = '0;
        reset = 1'b1;
        req4 = '0;
        reqf = '0;
        req16 = '0;
        test_reset();
        test_rr_rotation();
        test_fixed();
        test_held();
        test_reset_hold();
        test_back_to_back();
        test_wrap16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
